// File: rtl/i2c_target_regbank_if.sv
// Open-drain I2C bus view seen by the target: sampled SCL/SDA levels in, SDA pull-down request out.
interface i2c_target_regbank_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_target_regbank.sv
// I2C target register bank: oversampled SCL/SDA decode, address match, byte writes/reads into a small array.
// Optional SCL/SDA glitch filter is enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regbank #(
    parameter logic [6:0] TARGET_ADDR = 7'h55,
    parameter int         DEPTH       = 4,
    parameter int         FILTER_LEN  = 3,
    localparam int        IDX_W       = $clog2(DEPTH)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    i2c_target_regbank_if.slave   bus,
    output logic                  busy,
    output logic                  wr_stb,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [7:0]            wr_byte,
    input  logic [IDX_W-1:0]      host_idx,
    output logic [7:0]            host_data
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic       r_sclS1, r_sclS2, r_sdaS1, r_sdaS2;
    logic       r_sclPrev, r_sdaPrev;
    logic       w_scl, w_sda;
    logic       w_sclRise, w_sclFall, w_start, w_stop;

    state_t     r_state;
    logic [2:0] r_bitCnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_sdaOe;
    logic       r_busy;
    logic       r_wrStb;
    logic [IDX_W-1:0] r_wrIdx;
    logic [7:0] r_wrByte;
    logic [IDX_W-1:0] r_ptr;
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sclS1 <= 1'b1;
            r_sclS2 <= 1'b1;
            r_sdaS1 <= 1'b1;
            r_sdaS2 <= 1'b1;
        end else begin
            r_sclS1 <= bus.scl_i;
            r_sclS2 <= r_sclS1;
            r_sdaS1 <= bus.sda_i;
            r_sdaS2 <= r_sdaS1;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN) + 1;

    logic             r_sclFilt, r_sdaFilt;
    logic [CNT_W-1:0] r_sclCnt, r_sdaCnt;

    // A new level is accepted only once it has been stable for FILTER_LEN cycles.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sclFilt <= 1'b1;
            r_sclCnt  <= '0;
        end else if (r_sclS2 == r_sclFilt) begin
            r_sclCnt  <= '0;
        end else if (r_sclCnt == CNT_W'(FILTER_LEN - 1)) begin
            r_sclFilt <= r_sclS2;
            r_sclCnt  <= '0;
        end else begin
            r_sclCnt  <= r_sclCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sdaFilt <= 1'b1;
            r_sdaCnt  <= '0;
        end else if (r_sdaS2 == r_sdaFilt) begin
            r_sdaCnt  <= '0;
        end else if (r_sdaCnt == CNT_W'(FILTER_LEN - 1)) begin
            r_sdaFilt <= r_sdaS2;
            r_sdaCnt  <= '0;
        end else begin
            r_sdaCnt  <= r_sdaCnt + CNT_W'(1);
        end
    end

    assign w_scl = r_sclFilt;
    assign w_sda = r_sdaFilt;
`else
    logic w_unusedFilterLen;
    assign w_unusedFilterLen = (FILTER_LEN > 0);
    assign w_scl = r_sclS2;
    assign w_sda = r_sdaS2;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclPrev <= w_scl;
            r_sdaPrev <= w_sda;
        end
    end

    assign w_sclRise = w_scl & ~r_sclPrev;
    assign w_sclFall = ~w_scl & r_sclPrev;
    assign w_start   = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
    assign w_stop    = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;

    // START/STOP override whatever the byte engine is doing; ACK states use r_bitCnt as a phase flag.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_bitCnt <= 3'd0;
            r_shift  <= 8'h00;
            r_rw     <= 1'b0;
            r_sdaOe  <= 1'b0;
            r_busy   <= 1'b0;
            r_wrStb  <= 1'b0;
            r_wrIdx  <= '0;
            r_wrByte <= 8'h00;
            r_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            r_wrStb <= 1'b0;
            if (w_start) begin
                r_state  <= ADDR;
                r_bitCnt <= 3'd0;
                r_ptr    <= '0;
                r_busy   <= 1'b1;
                r_sdaOe  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_sdaOe  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    ADDR: if (w_sclRise) begin
                        r_shift <= {r_shift[6:0], w_sda};
                        if (r_bitCnt == 3'd7) begin
                            r_bitCnt <= 3'd0;
                            if (r_shift[6:0] == TARGET_ADDR) begin
                                r_state <= ADDR_ACK;
                                r_rw    <= w_sda;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end
                    ADDR_ACK: if (w_sclFall) begin
                        if (r_bitCnt == 3'd0) begin
                            r_sdaOe  <= 1'b1;
                            r_bitCnt <= 3'd1;
                        end else begin
                            r_bitCnt <= 3'd0;
                            if (r_rw) begin
                                r_state <= RD_DATA;
                                r_shift <= r_mem[r_ptr];
                                r_sdaOe <= ~r_mem[r_ptr][7];
                            end else begin
                                r_state <= WR_DATA;
                                r_sdaOe <= 1'b0;
                            end
                        end
                    end
                    WR_DATA: if (w_sclRise) begin
                        r_shift <= {r_shift[6:0], w_sda};
                        if (r_bitCnt == 3'd7) begin
                            r_mem[r_ptr] <= {r_shift[6:0], w_sda};
                            r_wrStb  <= 1'b1;
                            r_wrIdx  <= r_ptr;
                            r_wrByte <= {r_shift[6:0], w_sda};
                            r_ptr    <= r_ptr + IDX_W'(1);
                            r_bitCnt <= 3'd0;
                            r_state  <= WR_ACK;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end
                    WR_ACK: if (w_sclFall) begin
                        if (r_bitCnt == 3'd0) begin
                            r_sdaOe  <= 1'b1;
                            r_bitCnt <= 3'd1;
                        end else begin
                            r_sdaOe  <= 1'b0;
                            r_bitCnt <= 3'd0;
                            r_state  <= WR_DATA;
                        end
                    end
                    RD_DATA: if (w_sclFall) begin
                        if (r_bitCnt == 3'd7) begin
                            r_sdaOe  <= 1'b0;
                            r_ptr    <= r_ptr + IDX_W'(1);
                            r_bitCnt <= 3'd0;
                            r_state  <= RD_ACK;
                        end else begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sdaOe  <= ~r_shift[6];
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end
                    RD_ACK: if (w_sclRise) begin
                        if (!w_sda) begin
                            r_bitCnt <= 3'd1;
                        end else begin
                            r_state  <= WAIT_STOP;
                            r_sdaOe  <= 1'b0;
                        end
                    end else if (w_sclFall && r_bitCnt == 3'd1) begin
                        r_shift  <= r_mem[r_ptr];
                        r_sdaOe  <= ~r_mem[r_ptr][7];
                        r_bitCnt <= 3'd0;
                        r_state  <= RD_DATA;
                    end
                    WAIT_STOP: r_sdaOe <= 1'b0;
                    default:   r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_oe = r_sdaOe;
    assign busy       = r_busy;
    assign wr_stb     = r_wrStb;
    assign wr_idx     = r_wrIdx;
    assign wr_byte    = r_wrByte;
    assign host_data  = r_mem[host_idx];

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Directed bench for i2c_target_regbank: bit-banged I2C master on an open-drain SDA model.
module tb_i2c_target_regbank;

    localparam int IDX_W = 2;
    localparam int Q     = 8;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic             sclM = 1'b1;
    logic             sdaM = 1'b1;
    logic             busy, wr_stb;
    logic [IDX_W-1:0] wr_idx, host_idx;
    logic [7:0]       wr_byte, host_data;

    int checks = 0;
    int errors = 0;

    logic [IDX_W-1:0] wrIdxQ[$];
    logic [7:0]       wrByteQ[$];
    logic             oeSeen = 1'b0;

    i2c_target_regbank_if bus ();

    assign bus.scl_i = sclM;
    assign bus.sda_i = sdaM & ~bus.sda_oe;

    i2c_target_regbank #(.TARGET_ADDR(7'h55), .DEPTH(4), .FILTER_LEN(3)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .bus       (bus),
        .busy      (busy),
        .wr_stb    (wr_stb),
        .wr_idx    (wr_idx),
        .wr_byte   (wr_byte),
        .host_idx  (host_idx),
        .host_data (host_data)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (wr_stb === 1'b1) begin
            wrIdxQ.push_back(wr_idx);
            wrByteQ.push_back(wr_byte);
        end
        if (bus.sda_oe === 1'b1) oeSeen = 1'b1;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic readHost(input logic [IDX_W-1:0] idx, output logic [7:0] val);
        @(negedge PCLK);
        host_idx = idx;
        #1;
        val = host_data;
    endtask

    task automatic busStart();
        sdaM = 1'b1;
        waitCycles(Q);
        sclM = 1'b1;
        waitCycles(Q);
        sdaM = 1'b0;
        waitCycles(Q);
        sclM = 1'b0;
        waitCycles(Q);
    endtask

    task automatic busStop();
        sdaM = 1'b0;
        waitCycles(Q);
        sclM = 1'b1;
        waitCycles(Q);
        sdaM = 1'b1;
        waitCycles(Q);
    endtask

    task automatic sendBit(input logic b, input bit glitch);
        sdaM = b;
        waitCycles(Q);
        sclM = 1'b1;
        if (glitch) begin
            waitCycles(Q / 2);
            sclM = 1'b0;
            waitCycles(1);
            sclM = 1'b1;
            waitCycles(2 * Q - Q / 2 - 1);
        end else begin
            waitCycles(2 * Q);
        end
        sclM = 1'b0;
        waitCycles(Q);
    endtask

    task automatic sendByte(input logic [7:0] d, input int glitchBit, output logic ack);
        for (int i = 7; i >= 0; i--) sendBit(d[i], (i == glitchBit));
        sdaM = 1'b1;
        waitCycles(Q);
        sclM = 1'b1;
        waitCycles(Q);
        ack = bus.sda_i;
        waitCycles(Q);
        sclM = 1'b0;
        waitCycles(Q);
    endtask

    task automatic readByte(input logic masterAck, output logic [7:0] d);
        logic [7:0] tmp;
        tmp = 8'h00;
        sdaM = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            waitCycles(Q);
            sclM = 1'b1;
            waitCycles(Q);
            tmp[i] = bus.sda_i;
            waitCycles(Q);
            sclM = 1'b0;
            waitCycles(Q);
        end
        d = tmp;
        sendBit(masterAck ? 1'b0 : 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        PRESETn = 1'b0;
        waitCycles(3);
        PRESETn = 1'b1;
        waitCycles(2);
        checks++;
        if (bus.sda_oe !== 1'b0 || busy !== 1'b0 || wr_stb !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got oe=%b busy=%b stb=%b expected 0 0 0", bus.sda_oe, busy, wr_stb);
        end
        checks++;
        if (wr_idx !== 2'd0 || wr_byte !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_wr: got idx=%0d byte=%h expected 0 00", wr_idx, wr_byte);
        end
        for (int i = 0; i < 4; i++) begin
            readHost(IDX_W'(i), v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_mem%0d: got %h expected 00", i, v);
            end
        end
    endtask

    task automatic test_write_single();
        logic ack;
        logic [7:0] v;
        wrIdxQ.delete();
        wrByteQ.delete();
        busStart();
        sendByte(8'hAA, -1, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL wr1_addr_ack: got %b expected 0", ack); end
        sendByte(8'hAA, -1, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL wr1_data_ack: got %b expected 0", ack); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wr1_busy: got %b expected 1", busy); end
        busStop();
        waitCycles(4);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wr1_busy_stop: got %b expected 0", busy); end
        checks++;
        if (wrIdxQ.size() != 1 || wrIdxQ[0] !== 2'd0 || wrByteQ[0] !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL wr1_stb: got %0d pulses expected 1 pulse idx 0 byte AA", wrIdxQ.size());
        end
        readHost(2'd0, v);
        checks++;
        if (v !== 8'hAA) begin errors++; $display("[TB] FAIL wr1_mem0: got %h expected AA", v); end
    endtask

    task automatic test_write_read();
        logic ack;
        logic [7:0] v;
        busStart();
        sendByte(8'hAA, -1, ack);
        sendByte(8'h55, -1, ack);
        busStop();
        readHost(2'd0, v);
        checks++;
        if (v !== 8'h55) begin errors++; $display("[TB] FAIL wr2_mem0: got %h expected 55", v); end
        busStart();
        sendByte(8'hAB, -1, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_addr_ack: got %b expected 0", ack); end
        readByte(1'b0, v);
        checks++;
        if (v !== 8'h55) begin errors++; $display("[TB] FAIL rd_byte: got %b expected 01010101", v); end
        oeSeen = 1'b0;
        waitCycles(3 * Q);
        checks++;
        if (oeSeen !== 1'b0) begin errors++; $display("[TB] FAIL rd_nack_release: got oe=1 expected 0 after NACK"); end
        busStop();
    endtask

    task automatic test_wrong_addr();
        logic ack;
        logic [7:0] v;
        wrIdxQ.delete();
        wrByteQ.delete();
        oeSeen = 1'b0;
        busStart();
        sendByte(8'h46, -1, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("[TB] FAIL bad_addr_ack: got %b expected 1", ack); end
        sendByte(8'h99, -1, ack);
        busStop();
        checks++;
        if (oeSeen !== 1'b0 || wrIdxQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL bad_addr_silent: got oe_seen=%b pulses=%0d expected 0 0", oeSeen, wrIdxQ.size());
        end
        readHost(2'd0, v);
        checks++;
        if (v !== 8'h55) begin errors++; $display("[TB] FAIL bad_addr_mem0: got %h expected 55", v); end
    endtask

    task automatic test_multi_wrap();
        logic ack;
        logic [7:0] v;
        logic [7:0] data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [1:0] expIdx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] expMem [4] = '{8'h55, 8'h22, 8'h33, 8'h44};
        wrIdxQ.delete();
        wrByteQ.delete();
        busStart();
        sendByte(8'hAA, -1, ack);
        for (int i = 0; i < 5; i++) begin
            sendByte(data[i], -1, ack);
            checks++;
            if (ack !== 1'b0) begin errors++; $display("[TB] FAIL multi_ack%0d: got %b expected 0", i, ack); end
        end
        busStop();
        checks++;
        if (wrIdxQ.size() != 5) begin
            errors++;
            $display("[TB] FAIL multi_pulses: got %0d expected 5", wrIdxQ.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wrIdxQ[i] !== expIdx[i] || wrByteQ[i] !== data[i]) begin
                    errors++;
                    $display("[TB] FAIL multi_stb%0d: got idx=%0d byte=%h expected idx=%0d byte=%h",
                             i, wrIdxQ[i], wrByteQ[i], expIdx[i], data[i]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            readHost(IDX_W'(i), v);
            checks++;
            if (v !== expMem[i]) begin errors++; $display("[TB] FAIL multi_mem%0d: got %h expected %h", i, v, expMem[i]); end
        end
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic [7:0] v;
        wrIdxQ.delete();
        wrByteQ.delete();
        busStart();
        sendByte(8'hAA, -1, ack);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        busStart();
        checks++;
        if (wrIdxQ.size() != 0) begin errors++; $display("[TB] FAIL rs_partial: got %0d pulses expected 0", wrIdxQ.size()); end
        sendByte(8'hAA, -1, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rs_addr_ack: got %b expected 0", ack); end
        sendByte(8'h77, -1, ack);
        busStop();
        checks++;
        if (wrIdxQ.size() != 1 || wrIdxQ[0] !== 2'd0 || wrByteQ[0] !== 8'h77) begin
            errors++;
            $display("[TB] FAIL rs_stb: got %0d pulses expected 1 pulse idx 0 byte 77", wrIdxQ.size());
        end
        readHost(2'd0, v);
        checks++;
        if (v !== 8'h77) begin errors++; $display("[TB] FAIL rs_mem0: got %h expected 77", v); end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        logic [7:0] v;
        busStart();
        sendByte(8'hAB, -1, ack);
        checks++;
        if (bus.sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL rst_rd_bit7: got oe=%b expected 1", bus.sda_oe); end
        PRESETn = 1'b0;
        #1;
        checks++;
        if (bus.sda_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_rd_release: got oe=%b busy=%b expected 0 0", bus.sda_oe, busy);
        end
        sclM = 1'b1;
        sdaM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            readHost(IDX_W'(i), v);
            checks++;
            if (v !== 8'h00) begin errors++; $display("[TB] FAIL rst_rd_mem%0d: got %h expected 00", i, v); end
        end
        waitCycles(2);
        PRESETn = 1'b1;
        waitCycles(4);
    endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    task automatic test_glitch_filter();
        logic ack;
        wrIdxQ.delete();
        wrByteQ.delete();
        busStart();
        sendByte(8'hAA, -1, ack);
        sendByte(8'h3C, 2, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL glitch_ack: got %b expected 0", ack); end
        busStop();
        checks++;
        if (wrIdxQ.size() != 1 || wrByteQ[0] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL glitch_byte: got %0d pulses expected 1 pulse byte 3C", wrIdxQ.size());
        end
    endtask
`endif

    initial begin
        host_idx = '0;
        test_reset();
        test_write_single();
        test_write_read();
        test_wrong_addr();
        test_multi_wrap();
        test_repeated_start();
        test_reset_mid_read();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        test_glitch_filter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_regbank.md
Name: i2c_target_regbank

Overview:
- I2C target (slave) register bank sitting directly downstream of the APB-to-I2C bridge on the shared open-drain scl/sda bus.
- Oversamples scl/sda on PCLK, decodes START/STOP, address, R/W and data bytes, and ACKs matching transfers.
- Stores written bytes in a small register array and returns stored bytes on reads.
- Used as the bus-side target in bridge-level simulation and as a reusable on-chip target.

Parameters:
- TARGET_ADDR, 7'h55, 7-bit I2C address the block responds to.
- DEPTH, 4, number of 8-bit registers; power of two, 2..16.
- FILTER_LEN, 3, stability count for the optional glitch filter; ignored when the filter is compiled out.

Ports:
- PCLK  in  1  system clock; also the oversampling clock for scl/sda.
- PRESETn  in  1  asynchronous active-low reset.
- scl_i  in  1  bus SCL level.
- sda_i  in  1  bus SDA level.
- sda_oe  out  1  1 = pull SDA low; top level drives 0 when set, else z.
- busy  out  1  high from a detected START until the following STOP.
- wr_stb  out  1  one-cycle pulse when a received data byte is committed.
- wr_idx  out  $clog2(DEPTH)  register index written on wr_stb.
- wr_byte  out  8  data byte written on wr_stb.
- host_idx  in  $clog2(DEPTH)  local read index.
- host_data  out  8  mem[host_idx], combinational.

Behaviour:
- Reset (async assert, sync release on PCLK): sda_oe=0, busy=0, wr_stb=0, wr_idx=0, wr_byte=0, all mem=8'h00, ptr=0, state IDLE, sync flops=1.
- Input path: 2-flop synchronizer on scl_i/sda_i, then a previous-value register. Edge detection uses the synchronized and previous values.
- START: sda falls while scl high. STOP: sda rises while scl high. Both are detected in any state, including mid-byte.
- START (including repeated START): state ADDR, bit counter=0, ptr=0, busy=1, sda_oe=0.
- STOP: state IDLE, busy=0, sda_oe=0.
- Data is sampled on the synchronized SCL rising edge, MSB first.
- sda_oe changes only on the PCLK cycle after a synchronized SCL falling edge. Latency from bus SCL fall to sda_oe change is 3 PCLK.
- Constraint: SCL low phase must be at least 4 PCLK.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - On the 8th rise: if addr==TARGET_ADDR, go to ADDR_ACK and latch rw.
    - Otherwise go to IDLE; the target stays silent until the next START.
  - ADDR_ACK: sda_oe=1 for one SCL period. On the following fall, go to WR_DATA if rw=0, or RD_DATA if rw=1.
    - RD_DATA loads shift=mem[ptr] and drives bit 7 immediately.
  - WR_DATA: shift 8 bits.
    - On the 8th rise: mem[ptr]<=byte; wr_stb=1 for one cycle with wr_idx=ptr and wr_byte=byte; ptr<=ptr+1 (wraps modulo DEPTH).
    - Then go to WR_ACK.
  - WR_ACK: sda_oe=1 for one SCL period, then back to WR_DATA.
  - RD_DATA: sda_oe = ~shift[7]; shift left after each SCL fall.
    - After 8 bits: release SDA, ptr<=ptr+1 (wraps), go to RD_ACK.
  - RD_ACK: sample master ACK on SCL rise.
    - sda=0: load mem[ptr] and continue in RD_DATA.
    - sda=1 (NACK): go to WAIT_STOP with sda_oe=0.
  - WAIT_STOP: sda_oe=0; only START/STOP leave this state.
- Bus-side write and host read of the same index in the same cycle: host_data shows the old value; the new value appears next cycle.
- Reset asserted mid-transfer: immediate return to reset values. The bus transfer is abandoned and SDA is released.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined:
  - A filter follows each synchronizer. The filtered value updates only after the synchronized input has held a new level for FILTER_LEN consecutive PCLK cycles.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - SCL-fall-to-sda_oe latency becomes 3+FILTER_LEN PCLK.
  - SCL low phase must be at least FILTER_LEN+4 PCLK.
- Undefined: no filter; latency as stated in Behaviour.

Test Plan:
- Write 0xAA to addr 0x55 -> ACK after address and after data; wr_stb once with wr_idx=0, wr_byte=8'hAA; mem[0]=8'hAA; busy falls at STOP.
- Second transaction writing 0x55, then a read from 0x55 -> mem[0]=8'h55; read byte on SDA is 01010101; master NACK -> sda_oe=0 until STOP.
- Address 0x23 write -> no ACK (SDA stays high on the 9th clock); no wr_stb; mem unchanged.
- Multi-byte write 0x11,0x22,0x33,0x44,0x55 with DEPTH=4 -> mem[0]=0x55 (wrap), mem[1..3]=0x22,0x33,0x44; five wr_stb pulses with idx 0,1,2,3,0.
- Repeated START after the 3rd data bit of a write -> partial byte discarded; no wr_stb; new address phase decoded correctly.
- PRESETn low mid read-byte -> sda_oe=0 within the same cycle; mem cleared to 0.
- With I2C_TARGET_GLITCH_FILTER_EN defined: 1-PCLK low glitch on SCL during a data bit -> no extra bit shifted; byte received intact.
